// File: rtl/parity_frame_checker.sv
// parity_frame_checker: serial start/data/parity/stop deframer with parity check.
// Define PARITY_FRAME_CHECKER_ERR_CNT_EN to build the saturating error counter.

module parity_frame_checker #(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              x,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy,
    output logic [7:0]        err_count
);

    localparam int              CW   = $clog2(DATA_W + 1);
    localparam logic [CW-1:0]   LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       cnt;
    logic                run_par;
    logic                perr;
    logic [DATA_W-1:0]   shreg;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a 0 stop bit still returns to IDLE
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (!x) state_nxt = DATA;
            DATA:    if (cnt == LAST) state_nxt = PARITY;
            PARITY:  state_nxt = STOP;
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bit counter, data capture and running parity
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            run_par <= 1'b0;
            perr    <= 1'b0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!x) begin
                        cnt     <= '0;
                        run_par <= 1'b0;
                    end
                end
                DATA: begin
                    for (int i = 0; i < DATA_W; i++) begin
                        if (cnt == CW'(i)) shreg[i] <= x;
                    end
                    run_par <= run_par ^ x;
                    cnt     <= cnt + CW'(1);
                end
                PARITY: begin
                    perr <= run_par ^ x ^ PARITY_ODD;
                end
                default: begin
                end
            endcase
        end
    end

    // Frame completion: word and flags are published together with valid
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid      <= 1'b0;
            data_out   <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid <= (state == STOP);
            if (state == STOP) begin
                data_out   <= shreg;
                parity_err <= perr;
                frame_err  <= ~x;
            end
        end
    end

    assign busy = (state != IDLE);

`ifdef PARITY_FRAME_CHECKER_ERR_CNT_EN
    // Saturating count of completed frames carrying any error
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= 8'd0;
        end else if (state == STOP && (perr || !x)
                     && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// tb_parity_frame_checker: table vectors, corner sequences and random frames
// against a rule-level model for even and odd parity instances.

module tb_parity_frame_checker;

`ifdef PARITY_FRAME_CHECKER_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       x = 1'b1;
    logic [7:0] data_out, data_out_o;
    logic       valid, valid_o;
    logic       parity_err, parity_err_o;
    logic       frame_err, frame_err_o;
    logic       busy, busy_o;
    logic [7:0] err_count, err_count_o;

    int checks = 0;
    int errors = 0;
    int nframes = 0;
    int ecnt_e = 0;
    int ecnt_o = 0;
    int cyc = 0;
    int nvalid = 0;
    int last1 = 0;
    int last2 = 0;

    parity_frame_checker #(.DATA_W(8), .PARITY_ODD(1'b0)) dut (
        .clock(clock), .reset_n(reset_n), .x(x),
        .data_out(data_out), .valid(valid),
        .parity_err(parity_err), .frame_err(frame_err),
        .busy(busy), .err_count(err_count)
    );

    parity_frame_checker #(.DATA_W(8), .PARITY_ODD(1'b1)) dut_odd (
        .clock(clock), .reset_n(reset_n), .x(x),
        .data_out(data_out_o), .valid(valid_o),
        .parity_err(parity_err_o), .frame_err(frame_err_o),
        .busy(busy_o), .err_count(err_count_o)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        cyc++;
        if (valid) begin
            nvalid++;
            last2 = last1;
            last1 = cyc;
        end
    end

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       s;
        logic       pe_e;
        logic       pe_o;
        logic       fe;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic perr_of(input logic [7:0] d, input logic p,
                                     input bit odd);
        int ones;
        ones = $countones(d) + int'(p);
        return (ones % 2) != int'(odd);
    endfunction

    task automatic drive(input logic b);
        @(negedge clock);
        x = b;
    endtask

    task automatic frame(input logic [7:0] d, input logic p, input logic s,
                         input logic pe_e, input logic pe_o, input logic fe);
        @(negedge clock);
        chk("idle_busy", busy, 0);
        chk("valid_fall", valid, 0);
        x = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (i == 0) chk("busy_rise", busy, 1);
            x = d[i];
        end
        drive(p);
        drive(s);
        @(negedge clock);
        x = 1'b1;
        nframes++;
        if ((pe_e || fe) && ecnt_e < 255) ecnt_e++;
        if ((pe_o || fe) && ecnt_o < 255) ecnt_o++;
        chk("valid", valid, 1);
        chk("data_out", data_out, d);
        chk("parity_err", parity_err, pe_e);
        chk("frame_err", frame_err, fe);
        chk("busy_fall", busy, 0);
        chk("err_count", err_count, CNT_EN ? ecnt_e : 0);
        chk("odd_valid", valid_o, 1);
        chk("odd_data", data_out_o, d);
        chk("odd_parity_err", parity_err_o, pe_o);
        chk("odd_frame_err", frame_err_o, fe);
        chk("odd_err_count", err_count_o, CNT_EN ? ecnt_o : 0);
    endtask

    initial begin
        logic [7:0] d;
        logic       p;
        logic       s;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'hFE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        #1;
        chk("rst_valid", valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", err_count, 0);
        @(negedge clock);
        reset_n = 1'b1;
        drive(1'b1);
        drive(1'b1);

        for (int i = 0; i < 7; i++) begin
            frame(vecs[i].d, vecs[i].p, vecs[i].s,
                  vecs[i].pe_e, vecs[i].pe_o, vecs[i].fe);
            if (i == 4) chk("b2b_gap", last1 - last2, 12);
        end

        @(negedge clock);
        x = 1'b0;
        drive(1'b1);
        drive(1'b0);
        drive(1'b1);
        drive(1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        ecnt_e = 0;
        ecnt_o = 0;
        chk("midrst_busy", busy, 0);
        chk("midrst_data", data_out, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_cnt", err_count, 0);
        chk("midrst_odd_busy", busy_o, 0);
        @(negedge clock);
        reset_n = 1'b1;
        x = 1'b1;
        frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 100; i++) begin
            d = 8'($urandom_range(0, 255));
            p = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 3) != 0);
            frame(d, p, s, perr_of(d, p, 1'b0), perr_of(d, p, 1'b1), !s);
        end

        for (int i = 0; i < 300; i++) begin
            d = 8'($urandom_range(0, 255));
            p = 1'($urandom_range(0, 1));
            frame(d, p, 1'b0, perr_of(d, p, 1'b0), perr_of(d, p, 1'b1), 1'b1);
        end
        chk("sat_count", err_count, CNT_EN ? 255 : 0);

        @(negedge clock);
        chk("valid_pulses", nvalid, nframes);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
